// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and its shared-memory datapath.
// The slave modport is the sequencer side; the master modport is the datapath/memory side.
interface multicycle_control_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic       Illegal;
  logic       MemErr;
  logic [3:0] State;

  modport slave (
    input  OP, Funct, Zero, MemReady,
    output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, Illegal, MemErr, State
  );

  modport master (
    output OP, Funct, Zero, MemReady,
    input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, Illegal, MemErr, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: Moore FSM with Zero/MemReady terms, one memory access at a time,
// and a watchdog that parks the machine in HALT when memory never answers.
module multicycle_control #(
  parameter int WAIT_LIMIT = 16
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_LW_WB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_R_WB   = 4'd7,
    S_EXEC_I = 4'd8,
    S_I_WB   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_RSVD   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          mem_state, stall, wd_fire;

  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic       illegal, mem_err;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [3:0] alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Watchdog: counts consecutive not-ready cycles in any memory state, cleared everywhere else.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign stall     = mem_state && !bus.MemReady;
  assign wd_fire   = stall && (wait_q == CW'(WAIT_LIMIT - 1));
  assign wait_d    = stall ? wait_q + 1'b1 : '0;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 4'b0001;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 4'b0001;
        case (bus.OP)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_R:                             state_d = (bus.Funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 4'b0001;
        state_d   = (bus.OP == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.MemReady) state_d = S_LW_WB;
      end
      S_LW_WB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b1111;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (bus.OP)
          OP_ORI:  alu_op = 4'b0101;
          OP_ANDI: alu_op = 4'b1101;
          OP_LUI:  alu_op = 4'b0110;
          default: alu_op = 4'b0100;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0011;
        pc_source = 2'b01;
        pc_write  = ((bus.OP == OP_BEQ) && bus.Zero) || ((bus.OP == OP_BNE) && !bus.Zero);
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        reg_write  = 1'b1;
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_source = 2'b11;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        mem_err = 1'b1;
        state_d = S_HALT;
      end
    endcase

    if (wd_fire) state_d = S_HALT;
  end

  // Every output is held low while reset is asserted, including FETCH's read request.
  assign bus.PCWrite  = reset & pc_write;
  assign bus.PCSource = reset ? pc_source : 2'b00;
  assign bus.IorD     = reset & iord;
  assign bus.MemRead  = reset & mem_read;
  assign bus.MemWrite = reset & mem_write;
  assign bus.IRWrite  = reset & ir_write;
  assign bus.RegDst   = reset ? reg_dst : 2'b00;
  assign bus.MemtoReg = reset ? mem_to_reg : 2'b00;
  assign bus.RegWrite = reset & reg_write;
  assign bus.ALUSrcA  = reset & alu_src_a;
  assign bus.ALUSrcB  = reset ? alu_src_b : 2'b00;
  assign bus.ALUOp    = reset ? alu_op : 4'b0000;
  assign bus.Illegal  = reset & illegal;
  assign bus.MemErr   = reset & mem_err;
  assign bus.State    = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-path reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with stalls and resets.
module tb_multicycle_control;

  localparam int WAIT_LIMIT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus();

  multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic       Illegal;
    logic       MemErr;
    logic [3:0] State;
  } outs_t;

  outs_t dut_vec;
  assign dut_vec = {bus.PCWrite, bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                    bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.Illegal, bus.MemErr, bus.State};

  // Reference model: current step plus the remaining step list of the instruction in flight.
  int m_state = 0;
  int m_wait  = 0;
  int path[$];

  function automatic bit known_op(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
  endfunction

  function automatic logic [3:0] imm_aluop(logic [5:0] op);
    case (op)
      6'h0d:   return 4'b0101;
      6'h0c:   return 4'b1101;
      6'h0f:   return 4'b0110;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic outs_t model_outs(int s, logic [5:0] op, logic zero, logic rdy);
    outs_t o;
    o = '0;
    o.State = 4'(s);
    case (s)
      0: begin
        o.MemRead = 1'b1; o.ALUSrcB = 2'b01; o.ALUOp = 4'b0001;
        if (rdy) begin o.IRWrite = 1'b1; o.PCWrite = 1'b1; end
      end
      1: begin o.ALUSrcB = 2'b11; o.ALUOp = 4'b0001; o.Illegal = !known_op(op); end
      2: begin o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = 4'b0001; end
      3: begin o.IorD = 1'b1; o.MemRead = 1'b1; end
      4: begin o.MemtoReg = 2'b01; o.RegWrite = 1'b1; end
      5: begin o.IorD = 1'b1; o.MemWrite = 1'b1; end
      6: begin o.ALUSrcA = 1'b1; o.ALUOp = 4'b1111; end
      7: begin o.RegDst = 2'b01; o.RegWrite = 1'b1; end
      8: begin o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = imm_aluop(op); end
      9: o.RegWrite = 1'b1;
      10: begin
        o.ALUSrcA = 1'b1; o.ALUOp = 4'b0011; o.PCSource = 2'b01;
        o.PCWrite = ((op == 6'h04) && zero) || ((op == 6'h05) && !zero);
      end
      11: begin o.PCSource = 2'b10; o.PCWrite = 1'b1; end
      12: begin
        o.RegDst = 2'b10; o.MemtoReg = 2'b10; o.RegWrite = 1'b1;
        o.PCSource = 2'b10; o.PCWrite = 1'b1;
      end
      13: begin o.PCSource = 2'b11; o.PCWrite = 1'b1; end
      default: o.MemErr = 1'b1;
    endcase
    return o;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0;
      m_wait  = 0;
      path.delete();
    end else if (m_state != 15) begin
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !bus.MemReady) begin
        m_wait++;
        if (m_wait == WAIT_LIMIT) m_state = 15;
      end else begin
        m_wait = 0;
        if (m_state == 0) path = {1};
        else if (m_state == 1) begin
          if (bus.OP == 6'h23) path = {2, 3, 4, 0};
          else if (bus.OP == 6'h2b) path = {2, 5, 0};
          else if (bus.OP == 6'h00 && bus.Funct == 6'h08) path = {13, 0};
          else if (bus.OP == 6'h00) path = {6, 7, 0};
          else if (bus.OP inside {6'h08, 6'h0c, 6'h0d, 6'h0f}) path = {8, 9, 0};
          else if (bus.OP inside {6'h04, 6'h05}) path = {10, 0};
          else if (bus.OP == 6'h02) path = {11, 0};
          else if (bus.OP == 6'h03) path = {12, 0};
          else path = {0};
        end
        m_state = path.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    outs_t e;
    if (!reset) e = '0;
    else e = model_outs(m_state, bus.OP, bus.Zero, bus.MemReady);
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t model_state=%0d got=%h expected=%h", $time, m_state, dut_vec, e);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero);
    int n;
    n = 0;
    tick();
    while (bus.State != 4'd0 && n < 40) begin
      tick();
      n++;
    end
    chk("start_in_fetch", bus.State, 0);
    bus.OP = op;
    bus.Funct = fn;
    bus.Zero = zero;
    bus.MemReady = 1'b1;
  endtask

  task automatic wait_state(input int s, input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.State == 4'(s)) break;
    end
    chk(name, bus.State, s);
  endtask

  int addi_exp[5] = '{0, 1, 8, 9, 0};

  initial begin
    int st[5];
    logic rw[5];
    logic [3:0] aop[5];
    int stall_left;
    int k;
    logic [5:0] ops[12];
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

    bus.OP = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    @(negedge clk);
    chk("reset_state", bus.State, 0);
    chk("reset_memread", bus.MemRead, 0);
    chk("reset_memerr", bus.MemErr, 0);
    tick(); tick();
    reset = 1'b1;

    // ADDI right after reset with memory always ready
    bus.OP = 6'h08;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      st[i] = int'(bus.State); rw[i] = bus.RegWrite; aop[i] = bus.ALUOp;
    end
    for (int i = 0; i < 5; i++) begin
      chk("addi_state", st[i], addi_exp[i]);
      chk("addi_regwrite", rw[i], (i == 3) ? 1 : 0);
    end
    chk("addi_aluop", aop[2], 4'b0100);

    // LW with three not-ready cycles in MEMRD
    start_instr(6'h23, 6'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.State == 4'd3) break;
    end
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_hold_state", bus.State, 3);
      chk("lw_hold_memread", bus.MemRead, 1);
      chk("lw_hold_iord", bus.IorD, 1);
      tick();
    end
    bus.MemReady = 1'b1;
    @(negedge clk);
    chk("lw_ready_state", bus.State, 3);
    chk("lw_ready_memread", bus.MemRead, 1);
    @(negedge clk);
    chk("lw_wb_state", bus.State, 4);
    chk("lw_wb_memtoreg", bus.MemtoReg, 2'b01);

    start_instr(6'h04, 6'h00, 1'b1);
    wait_state(10, "beq_state");
    chk("beq_pcwrite", bus.PCWrite, 1);
    chk("beq_pcsource", bus.PCSource, 2'b01);
    @(negedge clk);
    chk("beq_next", bus.State, 0);

    start_instr(6'h05, 6'h00, 1'b1);
    wait_state(10, "bne_state");
    chk("bne_pcwrite", bus.PCWrite, 0);
    @(negedge clk);
    chk("bne_next", bus.State, 0);

    start_instr(6'h03, 6'h00, 1'b0);
    wait_state(12, "jal_state");
    chk("jal_regdst", bus.RegDst, 2'b10);
    chk("jal_memtoreg", bus.MemtoReg, 2'b10);
    chk("jal_regwrite", bus.RegWrite, 1);
    chk("jal_pcwrite", bus.PCWrite, 1);

    start_instr(6'h00, 6'h08, 1'b0);
    wait_state(13, "jr_state");
    chk("jr_pcsource", bus.PCSource, 2'b11);

    start_instr(6'h3f, 6'h00, 1'b0);
    wait_state(1, "illegal_decode");
    chk("illegal_pulse", bus.Illegal, 1);
    chk("illegal_regwrite", bus.RegWrite, 0);
    chk("illegal_pcwrite", bus.PCWrite, 0);
    @(negedge clk);
    chk("illegal_next", bus.State, 0);
    chk("illegal_cleared", bus.Illegal, 0);

    // Memory never answers a fetch: watchdog must halt after WAIT_LIMIT cycles
    start_instr(6'h08, 6'h00, 1'b0);
    bus.MemReady = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      chk("wd_fetch_hold", bus.State, 0);
    end
    @(negedge clk);
    chk("wd_halt_state", bus.State, 15);
    chk("wd_memerr", bus.MemErr, 1);
    chk("wd_halt_memread", bus.MemRead, 0);
    bus.MemReady = 1'b1;
    @(negedge clk);
    chk("wd_halt_sticky", bus.State, 15);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("wd_reset_memerr", bus.MemErr, 0);
    chk("wd_reset_state", bus.State, 0);
    chk("wd_reset_memread", bus.MemRead, 0);
    tick();
    reset = 1'b1;

    // Randomized traffic: new opcode each fetch, random stalls, long stall bursts, random resets
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!reset) reset = 1'b1;
      else if (m_state == 15 || $urandom_range(0, 299) == 0) reset = 1'b0;
      if (m_state == 0) begin
        k = $urandom_range(0, 12);
        bus.OP = (k == 12) ? 6'($urandom_range(16, 31)) : ops[k];
        bus.Funct = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      end
      bus.Zero = 1'($urandom);
      if (stall_left == 0 && $urandom_range(0, 99) == 0) stall_left = $urandom_range(5, 20);
      if (stall_left > 0) begin
        bus.MemReady = 1'b0;
        stall_left--;
      end else begin
        bus.MemReady = ($urandom_range(0, 3) != 0);
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
